// File: rtl/irq_priority_capture.sv
// Interrupt request capture: latches request lines into a pending register and
// presents the highest-priority enabled pending line on a valid/ready output.
module irq_priority_capture #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic          out_ready,
  input  logic          clr_drop,
  output logic          out_valid,
  output logic [W-1:0]  out_idx,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] drop_cnt
);

  localparam int PW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_out_valid;
  logic          w_valid_nxt;
  logic [W-1:0]  r_out_idx;
  logic [W-1:0]  w_idx_nxt;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  w_pending_nxt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_drop_nxt;

  logic          w_hs;
  logic [N-1:0]  w_clr_vec;
  logic [N-1:0]  w_drop_vec;
  logic [N-1:0]  w_elig;
  logic [PW-1:0] w_drop_num;
  logic [CW:0]   w_cnt_sum;

  // Index of the highest set bit; bit N-1 has top priority.
  function automatic logic [W-1:0] f_prio(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        idx = i[W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] f_popcnt(input logic [N-1:0] v);
    logic [PW-1:0] cnt;
    cnt = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{(PW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  assign w_hs      = (r_state == ST_SEND) && r_out_valid && out_ready;
  assign w_elig    = r_pending & mask;
  assign w_drop_num = f_popcnt(w_drop_vec);
  assign w_cnt_sum = {1'b0, r_drop_cnt} + {{(CW+1-PW){1'b0}}, w_drop_num};

  // Pending update: a same-edge request on the granted bit re-arms it without a drop.
  always_comb begin
    w_clr_vec = {N{1'b0}};
    if (w_hs) begin
      w_clr_vec = {{(N-1){1'b0}}, 1'b1} << r_out_idx;
    end else begin
      w_clr_vec = {N{1'b0}};
    end
    w_drop_vec    = req & r_pending & ~w_clr_vec;
    w_pending_nxt = (r_pending & ~w_clr_vec) | req;
  end

  // Saturating drop counter; clear has precedence over any increment.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (clr_drop) begin
      w_drop_nxt = {CW{1'b0}};
    end else if (w_cnt_sum[CW]) begin
      w_drop_nxt = CNT_MAX;
    end else begin
      w_drop_nxt = w_cnt_sum[CW-1:0];
    end
  end

  // Grant FSM next-state; the presented index is frozen while in SEND.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_out_valid;
    w_idx_nxt   = r_out_idx;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_idx_nxt   = f_prio(w_elig);
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_idx_nxt   = {W{1'b0}};
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_idx   <= {W{1'b0}};
      r_pending   <= {N{1'b0}};
      r_drop_cnt  <= {CW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_idx   <= w_idx_nxt;
      r_pending   <= w_pending_nxt;
      r_drop_cnt  <= w_drop_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign pending   = r_pending;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_irq_priority_capture.sv
// Directed-vector bench for irq_priority_capture with hand-computed expectations.
module tb_irq_priority_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_ready;
  logic       clr_drop;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic [7:0] drop_cnt;

  int n_vec;
  int n_miss;

  irq_priority_capture #(.N(8), .W(3), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .out_ready (out_ready),
    .clr_drop  (clr_drop),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; req = 8'h00; mask = 8'h00; out_ready = 1'b0; clr_drop = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_pend", 32'(pending), 32'h00);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Two requests, highest first, one bubble between grants
    rst_n = 1'b1; mask = 8'hFF; out_ready = 1'b1; req = 8'h81;
    tick(); req = 8'h00;
    check("t1_pend", 32'(pending), 32'h81);
    check("t1_nvalid", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid7", 32'(out_valid), 32'd1);
    check("t1_idx7", 32'(out_idx), 32'd7);
    tick();
    check("t1_bubble", 32'(out_valid), 32'd0);
    check("t1_pend01", 32'(pending), 32'h01);
    tick();
    check("t1_idx0", 32'(out_idx), 32'd0);
    tick();
    check("t1_pend0", 32'(pending), 32'h00);
    check("t1_drop0", 32'(drop_cnt), 32'd0);

    // Stalled consumer: index held stable
    out_ready = 1'b0; req = 8'h34;
    tick(); req = 8'h00;
    tick();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_idx5", 32'(out_idx), 32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold", 32'({out_valid, out_idx}), 32'({1'b1, 3'd5}));
    end
    out_ready = 1'b1;
    tick();
    check("t2_pend14", 32'(pending), 32'h14);
    tick();
    check("t2_idx4", 32'(out_idx), 32'd4);
    tick(); tick();
    check("t2_idx2", 32'(out_idx), 32'd2);
    tick();
    check("t2_pend0", 32'(pending), 32'h00);

    // Masking keeps upper bits pending until unmasked
    mask = 8'h0F; req = 8'hC2;
    tick(); req = 8'h00;
    tick();
    check("t3_idx1", 32'(out_idx), 32'd1);
    tick();
    check("t3_pendC0", 32'(pending), 32'hC0);
    tick();
    check("t3_masked", 32'(out_valid), 32'd0);
    mask = 8'hFF;
    tick();
    check("t3_idx7", 32'(out_idx), 32'd7);
    tick(); tick();
    check("t3_idx6", 32'(out_idx), 32'd6);
    tick();
    check("t3_pend0", 32'(pending), 32'h00);

    // Held requests drop 2 per cycle after capture
    out_ready = 1'b0; req = 8'h18;
    for (int i = 0; i < 4; i++) tick();
    check("t4_drop6", 32'(drop_cnt), 32'd6);
    check("t4_idx4", 32'({out_valid, out_idx}), 32'({1'b1, 3'd4}));
    clr_drop = 1'b1;
    tick();
    check("t4_clr_wins", 32'(drop_cnt), 32'd0);
    req = 8'h00;
    tick(); clr_drop = 1'b0;
    check("t4_clr", 32'(drop_cnt), 32'd0);

    // Same-edge request on the granted bit re-arms it without a drop
    out_ready = 1'b1; req = 8'h10;
    tick(); req = 8'h00;
    check("t5_pend18", 32'(pending), 32'h18);
    check("t5_drop0", 32'(drop_cnt), 32'd0);
    check("t5_bubble", 32'(out_valid), 32'd0);
    tick();
    check("t5_regrant4", 32'({out_valid, out_idx}), 32'({1'b1, 3'd4}));
    tick(); tick(); tick();
    check("t5_pend0", 32'(pending), 32'h00);

    // Drop counter saturation
    out_ready = 1'b0; req = 8'hFF;
    for (int i = 0; i < 32; i++) tick();
    check("t6_drop248", 32'(drop_cnt), 32'd248);
    tick();
    check("t6_sat", 32'(drop_cnt), 32'd255);
    tick();
    check("t6_sat_hold", 32'(drop_cnt), 32'd255);
    req = 8'h00; clr_drop = 1'b1;
    tick(); clr_drop = 1'b0;
    check("t6_clr", 32'(drop_cnt), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("t6_drain", 32'({out_valid, pending}), 32'h000);

    // Reset mid-grant abandons it
    out_ready = 1'b0; req = 8'h40;
    tick(); req = 8'h00;
    tick(); req = 8'h40;
    tick(); req = 8'h00;
    check("t7_send6", 32'({out_valid, out_idx}), 32'({1'b1, 3'd6}));
    check("t7_drop1", 32'(drop_cnt), 32'd1);
    rst_n = 1'b0; out_ready = 1'b1;
    tick(); rst_n = 1'b1;
    check("t7_valid", 32'(out_valid), 32'd0);
    check("t7_pend", 32'(pending), 32'h00);
    check("t7_drop", 32'(drop_cnt), 32'd0);
    check("t7_idx", 32'(out_idx), 32'd0);
    tick();
    check("t7_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/irq_priority_capture.md
Name: irq_priority_capture

Overview:
- Sequential front end for the 8-to-3 priority encoding stage.
- Latches 8 request lines into a pending register and applies an enable mask.
- Presents the highest-priority pending index on a valid/ready output.
- Clears the granted pending bit on handshake and counts requests lost to an already-pending bit.

Parameters:
- N, 8, number of request lines.
- W, 3, index width; must equal clog2(N).
- CW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; takes effect only on a rising edge of clk.
- req  input  N  request lines, sampled every cycle; level or single-cycle pulse.
- mask  input  N  per-line enable, 1 = eligible for grant.
- out_ready  input  1  consumer accepts out_idx this cycle.
- clr_drop  input  1  clear drop_cnt.
- out_valid  output  1  out_idx holds a granted request.
- out_idx  output  W  granted line index; bit N-1 is highest priority.
- pending  output  N  current pending register.
- drop_cnt  output  CW  saturating count of lost requests.

Behaviour:
Reset:
- On a rising edge with rst_n=0: pending=0, out_valid=0, out_idx=0, drop_cnt=0, FSM=IDLE.
- Reset asserted mid-grant abandons the grant; no handshake is recorded.

Capture:
- Each edge: pending <= pending | req, minus any bit cleared by a handshake (see SEND).
- Drop event: req[i]=1 while pending[i]=1 already, and pending[i] is not being cleared this edge.
- drop_cnt increments by the number of dropped bits per edge (0..N) and saturates at 2^CW-1.
- clr_drop=1 forces drop_cnt <= 0; it wins over increments on the same edge.

FSM, two states:
- IDLE:
  - out_valid=0.
  - If (pending & mask) != 0 on the registered values, load out_idx with the index of the highest set bit, set out_valid=1, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - out_valid=1; out_idx is held stable regardless of mask/req changes.
  - On out_valid & out_ready: clear pending[out_idx], set out_valid=0, go to IDLE.
  - A req[out_idx]=1 on that same edge re-sets the bit: new request wins, no drop counted.
  - While in SEND, req on the presented bit before the handshake counts as a drop.

Latency and throughput:
- req high in the cycle before edge k sets pending at edge k.
- With out_ready held high, out_valid rises at edge k+1.
- Minimum 2 cycles per grant (one IDLE bubble); back-to-back grants alternate valid high/low.

Priority and masking:
- Fixed: index N-1 highest, index 0 lowest.
- Masked bits stay pending and are granted once unmasked.
- A mask change during SEND does not retract the current grant.

Test Plan:
- Reset, then req=8'b1000_0001 for one cycle, out_ready=1, mask=8'hFF -> out_idx=7, then two cycles later out_idx=0; pending returns to 8'h00; drop_cnt=0.
- req=8'b0011_0100 pulse, out_ready=0 for 5 cycles -> out_valid=1, out_idx=5 held stable; raise out_ready -> next grant out_idx=4, then 2.
- mask=8'b0000_1111, req=8'b1100_0010 -> only out_idx=1 granted; pending stays 8'b1100_0000; set mask=8'hFF -> grants 7 then 6.
- Hold req=8'h18 high for 4 cycles with out_ready=0 -> drop_cnt counts 2 per cycle after the first capture (6 total); clr_drop=1 -> drop_cnt=0.
- Drive req[out_idx]=1 on the same edge as the handshake -> pending bit remains set, drop_cnt unchanged, same index re-granted.
- Assert rst_n=0 for one edge while in SEND with pending=8'h40 -> next cycle out_valid=0, pending=0, drop_cnt=0, FSM=IDLE.
